// File: rtl/seq1101_rr_sched.sv
// rtl/seq1101_rr_sched.sv - round-robin shared "1101" Mealy detector over NCH serial channels
// One granted bit per cycle runs through the shared next-state logic; per-channel contexts are saved.
module seq1101_rr_sched #(
   parameter int NCH     = 4,
   parameter int CW      = 3,
   parameter int OVERLAP = 0,
   localparam int PW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    din,
   input  logic [NCH-1:0]    clr,
   output logic [NCH-1:0]    gnt,
   output logic              match,
   output logic [PW-1:0]     match_ch,
   output logic [NCH*CW-1:0] hit_cnt
);

   typedef enum logic [1:0] {S0, S1, S11, S110} ctx_t;

   ctx_t              ctx [NCH];
   logic [CW-1:0]     cnt [NCH];
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     gidx;
   logic              found;
   logic [NCH-1:0]    rot;
   ctx_t              nxt;
   logic              hit;

   // State register: contexts, pointer, counters and the registered match pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         match    <= 1'b0;
         match_ch <= '0;
         for (int i = 0; i < NCH; i++) begin
            ctx[i] <= S0;
            cnt[i] <= '0;
         end
      end else begin
         match <= 1'b0;
         if (found) begin
            ptr       <= (gidx == PW'(NCH - 1)) ? '0 : gidx + 1'b1;
            ctx[gidx] <= nxt;
            if (hit && !clr[gidx]) begin
               match    <= 1'b1;
               match_ch <= gidx;
               if (cnt[gidx] != '1)
                  cnt[gidx] <= cnt[gidx] + 1'b1;
            end
         end
         // Clear wins over the grant write-back above for the same channel
         for (int i = 0; i < NCH; i++) begin
            if (clr[i]) begin
               ctx[i] <= S0;
               cnt[i] <= '0;
            end
         end
      end
   end

   // Next-state: rotate requests so the search starts at ptr, then step the shared detector
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      rot   = NCH'({req, req} >> ptr);
      for (int off = 0; off < NCH; off++) begin
         if (!found && rot[off]) begin
            found = 1'b1;
            gidx  = PW'((int'(ptr) + off) % NCH);
         end
      end
      hit = 1'b0;
      nxt = ctx[gidx];
      case (ctx[gidx])
         S0:   nxt = din[gidx] ? S1  : S0;
         S1:   nxt = din[gidx] ? S11 : S0;
         S11:  nxt = din[gidx] ? S11 : S110;
         S110: begin
            nxt = S0;
            if (din[gidx]) begin
               hit = 1'b1;
               nxt = (OVERLAP != 0) ? S1 : S0;
            end
         end
         default: nxt = S0;
      endcase
   end

   // Outputs: one-hot grant, suppressed while reset is held
   always_comb begin
      gnt = '0;
      if (found && !rst)
         gnt[gidx] = 1'b1;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_cnt
      assign hit_cnt[i*CW +: CW] = cnt[i];
   end

endmodule

// File: tb/tb_seq1101_rr_sched.sv
// tb/tb_seq1101_rr_sched.sv - bench for seq1101_rr_sched, non-overlap and overlap instances side by side
module tb_seq1101_rr_sched;
   localparam int NCH = 4;
   localparam int CW  = 3;
   localparam int PW  = 2;
   localparam int SAT = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    req, din, clr;
   logic [NCH-1:0]    gnt0, gnt1;
   logic              match0, match1;
   logic [PW-1:0]     mch0, mch1;
   logic [NCH*CW-1:0] hc0, hc1;

   always #5 clk = ~clk;

   seq1101_rr_sched #(.NCH(NCH), .CW(CW), .OVERLAP(0)) dut (
      .clk(clk), .rst(rst), .req(req), .din(din), .clr(clr),
      .gnt(gnt0), .match(match0), .match_ch(mch0), .hit_cnt(hc0));

   seq1101_rr_sched #(.NCH(NCH), .CW(CW), .OVERLAP(1)) dut_ov (
      .clk(clk), .rst(rst), .req(req), .din(din), .clr(clr),
      .gnt(gnt1), .match(match1), .match_ch(mch1), .hit_cnt(hc1));

   int vecs = 0;
   int miss = 0;

   // Reference: arbitration pointer plus per-channel bit history since last hit (index 1 keeps history = overlap)
   int          m_ptr;
   int          m_len [2][NCH];
   logic [3:0]  m_sh  [2][NCH];
   int          m_cnt [2][NCH];
   logic        m_match [2];
   int          m_mch   [2];
   logic [NCH-1:0] exp_gnt, obs_gnt0, obs_gnt1;
   logic [3:0]  pat = 4'b1101;

   function automatic int model_pick(input logic [NCH-1:0] r);
      for (int k = 0; k < NCH; k++)
         if (r[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
      return -1;
   endfunction

   function automatic logic [NCH*CW-1:0] exp_hc(input int v);
      logic [NCH*CW-1:0] r;
      r = '0;
      for (int i = 0; i < NCH; i++) r[i*CW +: CW] = CW'(m_cnt[v][i]);
      return r;
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      for (int v = 0; v < 2; v++) begin
         m_match[v] = 1'b0;
         m_mch[v]   = 0;
         for (int i = 0; i < NCH; i++) begin
            m_len[v][i] = 0; m_sh[v][i] = '0; m_cnt[v][i] = 0;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; din = '0; clr = '0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Applies one cycle of inputs, samples gnt before the edge, advances the model, returns at negedge
   task automatic drive(input logic [NCH-1:0] r, input logic [NCH-1:0] d, input logic [NCH-1:0] c);
      int g;
      req = r; din = d; clr = c;
      #1;
      g = model_pick(r);
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      obs_gnt0 = gnt0;
      obs_gnt1 = gnt1;
      @(posedge clk);
      for (int v = 0; v < 2; v++) begin
         m_match[v] = 1'b0;
         if (g >= 0 && !c[g]) begin
            m_sh[v][g]  = {m_sh[v][g][2:0], d[g]};
            m_len[v][g] = m_len[v][g] + 1;
            if (m_len[v][g] >= 4 && m_sh[v][g] == 4'b1101) begin
               m_match[v] = 1'b1;
               m_mch[v]   = g;
               if (m_cnt[v][g] < SAT) m_cnt[v][g] = m_cnt[v][g] + 1;
               if (v == 0) begin m_len[v][g] = 0; m_sh[v][g] = '0; end
            end
         end
         for (int i = 0; i < NCH; i++)
            if (c[i]) begin m_len[v][i] = 0; m_sh[v][i] = '0; m_cnt[v][i] = 0; end
      end
      if (g >= 0) m_ptr = (g + 1) % NCH;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '1; din = '1; clr = '0;
      model_reset();
      @(negedge clk);
      vecs++; if (gnt0 !== '0 || gnt1 !== '0) begin miss++; $display("FAIL reset_gnt got %b/%b want 0000", gnt0, gnt1); end
      vecs++; if (match0 !== 1'b0 || mch0 !== '0) begin miss++; $display("FAIL reset_match got %b ch %0d want 0 ch 0", match0, mch0); end
      vecs++; if (hc0 !== '0 || hc1 !== '0) begin miss++; $display("FAIL reset_cnt got %h/%h want 0", hc0, hc1); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      for (int b = 0; b < 4; b++) begin
         drive(4'b0001, {3'b000, pat[3-b]}, 4'b0000);
         vecs++; if (obs_gnt0 !== 4'b0001) begin miss++; $display("FAIL single_gnt got %b want 0001", obs_gnt0); end
         vecs++; if (match0 !== (b == 3)) begin miss++; $display("FAIL single_match bit %0d got %b want %b", b, match0, b == 3); end
      end
      vecs++; if (mch0 !== 2'd0) begin miss++; $display("FAIL single_mch got %0d want 0", mch0); end
      vecs++; if (hc0[CW-1:0] !== 3'd1) begin miss++; $display("FAIL single_cnt got %0d want 1", hc0[CW-1:0]); end
   endtask

   task automatic test_overlap();
      logic [6:0] s = 7'b1101101;
      int n0 = 0, n1 = 0;
      do_reset();
      for (int b = 6; b >= 0; b--) begin
         drive(4'b0010, {2'b00, s[b], 1'b0}, 4'b0000);
         n0 += int'(match0); n1 += int'(match1);
         vecs++; if (match1 !== m_match[1] || match0 !== m_match[0]) begin miss++; $display("FAIL ovl_match got %b/%b want %b/%b", match0, match1, m_match[0], m_match[1]); end
      end
      vecs++; if (n0 != 1 || n1 != 2) begin miss++; $display("FAIL ovl_hits got %0d/%0d want 1/2", n0, n1); end
      vecs++; if (hc0[CW +: CW] !== 3'd1 || hc1[CW +: CW] !== 3'd2) begin miss++; $display("FAIL ovl_cnt got %0d/%0d want 1/2", hc0[CW +: CW], hc1[CW +: CW]); end
      vecs++; if (mch1 !== 2'd1) begin miss++; $display("FAIL ovl_mch got %0d want 1", mch1); end
   endtask

   task automatic test_all_channels();
      int ng [NCH];
      logic [NCH-1:0] d, want;
      do_reset();
      for (int i = 0; i < NCH; i++) ng[i] = 0;
      for (int c = 1; c <= 20; c++) begin
         for (int i = 0; i < NCH; i++) d[i] = (ng[i] < 4) ? pat[3 - ng[i]] : 1'b0;
         drive(4'b1111, d, 4'b0000);
         want = '0; want[(c - 1) % NCH] = 1'b1;
         vecs++; if (obs_gnt0 !== want) begin miss++; $display("FAIL rr_gnt cycle %0d got %b want %b", c, obs_gnt0, want); end
         vecs++; if (match0 !== (c >= 13 && c <= 16)) begin miss++; $display("FAIL rr_match cycle %0d got %b", c, match0); end
         if (c >= 13 && c <= 16) begin
            vecs++; if (mch0 !== PW'(c - 13)) begin miss++; $display("FAIL rr_mch cycle %0d got %0d want %0d", c, mch0, c - 13); end
         end
         ng[(c - 1) % NCH]++;
      end
      vecs++; if (hc0 !== {4{3'd1}}) begin miss++; $display("FAIL rr_cnt got %h want %h", hc0, {4{3'd1}}); end
   endtask

   task automatic test_interleave();
      int ch [9] = '{0, 2, 0, 2, 0, 0, 2, 2, 2};
      logic bt [9] = '{1, 0, 1, 0, 0, 1, 1, 0, 1};
      logic [NCH-1:0] r, d;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         r = '0; r[ch[k]] = 1'b1;
         d = '0; d[ch[k]] = bt[k];
         drive(r, d, 4'b0000);
         vecs++; if (match0 !== (k == 5)) begin miss++; $display("FAIL ilv_match step %0d got %b want %b", k, match0, k == 5); end
      end
      vecs++; if (mch0 !== 2'd0) begin miss++; $display("FAIL ilv_mch got %0d want 0", mch0); end
      vecs++; if (hc0[0 +: CW] !== 3'd1 || hc0[2*CW +: CW] !== 3'd0) begin miss++; $display("FAIL ilv_cnt got %h", hc0); end
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 9; n++)
         for (int b = 0; b < 4; b++)
            drive(4'b1000, {pat[3-b], 3'b000}, 4'b0000);
      vecs++; if (hc0[3*CW +: CW] !== 3'd7 || hc1[3*CW +: CW] !== 3'd7) begin miss++; $display("FAIL sat_cnt got %0d/%0d want 7", hc0[3*CW +: CW], hc1[3*CW +: CW]); end
      drive(4'b0000, 4'b0000, 4'b1000);
      vecs++; if (hc0[3*CW +: CW] !== 3'd0 || hc1[3*CW +: CW] !== 3'd0) begin miss++; $display("FAIL clr_cnt got %0d/%0d want 0", hc0[3*CW +: CW], hc1[3*CW +: CW]); end
      vecs++; if (hc0 !== exp_hc(0)) begin miss++; $display("FAIL clr_others got %h want %h", hc0, exp_hc(0)); end
   endtask

   task automatic test_reset_mid();
      drive(4'b0001, 4'b0001, 4'b0000);
      drive(4'b0001, 4'b0001, 4'b0000);
      drive(4'b0001, 4'b0000, 4'b0000);
      rst = 1'b1; din = 4'b0001;
      #1;
      vecs++; if (gnt0 !== '0 || match0 !== 1'b0 || hc0 !== '0 || mch0 !== '0) begin miss++; $display("FAIL rstmid_outs gnt %b match %b cnt %h ch %0d want all 0", gnt0, match0, hc0, mch0); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      drive(4'b0001, 4'b0001, 4'b0000);
      vecs++; if (match0 !== 1'b0 || match1 !== 1'b0) begin miss++; $display("FAIL rstmid_match got %b/%b want 0", match0, match1); end
   endtask

   task automatic test_random();
      logic [NCH-1:0] c;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         c = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
         drive(NCH'($urandom), NCH'($urandom), c);
         vecs++; if (obs_gnt0 !== exp_gnt || obs_gnt1 !== exp_gnt) begin miss++; $display("FAIL rnd_gnt n %0d got %b/%b want %b", n, obs_gnt0, obs_gnt1, exp_gnt); end
         vecs++; if (match0 !== m_match[0] || match1 !== m_match[1]) begin miss++; $display("FAIL rnd_match n %0d got %b/%b want %b/%b", n, match0, match1, m_match[0], m_match[1]); end
         vecs++; if (mch0 !== PW'(m_mch[0]) || mch1 !== PW'(m_mch[1])) begin miss++; $display("FAIL rnd_mch n %0d got %0d/%0d want %0d/%0d", n, mch0, mch1, m_mch[0], m_mch[1]); end
         vecs++; if (hc0 !== exp_hc(0) || hc1 !== exp_hc(1)) begin miss++; $display("FAIL rnd_cnt n %0d got %h/%h want %h/%h", n, hc0, hc1, exp_hc(0), exp_hc(1)); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overlap();
      test_all_channels();
      test_interleave();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
